// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow state register with legality check, settle window and pause
`timescale 1ns/1ps
module game_state_ctrl #(
   parameter int unsigned SETTLE  = 1,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         next_initial,
   input  logic [2:0]         next_new,
   input  logic [2:0]         next_move,
   input  logic [2:0]         next_remove,
   input  logic [2:0]         next_lose,
   input  logic               pause_toggle,
   output logic [2:0]         game_current_state,
   output logic               state_enter,
   output logic               illegal_req,
   output logic [2:0]         paused_from,
   output logic [DWELL_W-1:0] dwell_cnt
);

   localparam logic [2:0] ST_INITIAL   = 3'd0;
   localparam logic [2:0] ST_NEW_SHAPE = 3'd1;
   localparam logic [2:0] ST_MOVE      = 3'd2;
   localparam logic [2:0] ST_REMOVE    = 3'd3;
   localparam logic [2:0] ST_LOSE      = 3'd4;
   localparam logic [2:0] ST_PAUSE     = 3'd5;

   localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] SETTLE_CNT = DWELL_W'(SETTLE);

   logic [2:0]         r_state;
   logic [2:0]         r_paused_from;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_enter;
   logic               r_illegal;

   logic [2:0]         w_next_state;
   logic [2:0]         w_proposal;
   logic               w_illegal;
   logic               w_save_pause;
   logic               w_settled;
   logic               w_can_pause;
   logic               w_state_change;

   function automatic logic f_legal(input logic [2:0] from_st, input logic [2:0] to_st);
      logic ok;
      ok = 1'b0;
      case (from_st)
         ST_INITIAL:   ok = (to_st == ST_NEW_SHAPE);
         ST_NEW_SHAPE: ok = (to_st == ST_MOVE) || (to_st == ST_LOSE);
         ST_MOVE:      ok = (to_st == ST_REMOVE);
         ST_REMOVE:    ok = (to_st == ST_NEW_SHAPE);
         ST_LOSE:      ok = (to_st == ST_INITIAL);
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Only the handler owning the current state gets a say; PAUSE proposes "stay".
   always_comb begin
      w_proposal = r_state;
      case (r_state)
         ST_INITIAL:   w_proposal = next_initial;
         ST_NEW_SHAPE: w_proposal = next_new;
         ST_MOVE:      w_proposal = next_move;
         ST_REMOVE:    w_proposal = next_remove;
         ST_LOSE:      w_proposal = next_lose;
         default:      w_proposal = r_state;
      endcase
   end

   assign w_settled      = (r_dwell >= SETTLE_CNT);
   assign w_can_pause    = (r_state == ST_NEW_SHAPE) || (r_state == ST_MOVE) ||
                           (r_state == ST_REMOVE);
   assign w_state_change = (w_next_state != r_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_INITIAL;
         r_paused_from <= ST_INITIAL;
         r_dwell       <= '0;
         r_enter       <= 1'b1;
         r_illegal     <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_enter   <= w_state_change;
         r_illegal <= w_illegal;
         if (w_save_pause) begin
            r_paused_from <= r_state;
         end
         if (w_state_change) begin
            r_dwell <= '0;
         end else if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + DWELL_ONE;
         end
      end
   end

   // Pause requests win over handler proposals and ignore the settle window.
   always_comb begin
      w_next_state = r_state;
      w_illegal    = 1'b0;
      w_save_pause = 1'b0;
      if (r_state > ST_PAUSE) begin
         w_next_state = ST_INITIAL;
      end else if (pause_toggle && w_can_pause) begin
         w_next_state = ST_PAUSE;
         w_save_pause = 1'b1;
      end else if (pause_toggle && (r_state == ST_PAUSE)) begin
         w_next_state = r_paused_from;
      end else if ((r_state != ST_PAUSE) && w_settled && (w_proposal != r_state)) begin
         if (f_legal(r_state, w_proposal)) begin
            w_next_state = w_proposal;
         end else begin
            w_illegal = 1'b1;
         end
      end
   end

   always_comb begin
      game_current_state = r_state;
      state_enter        = r_enter;
      illegal_req        = r_illegal;
      paused_from        = r_paused_from;
      dwell_cnt          = r_dwell;
   end

endmodule
